// File: rtl/cc_wrap_serializer.sv
// Cache-line to AXI-style read-beat serializer.
// Pops a whole cache line (with burst mode and start beat) from a show-ahead
// FIFO and replays it one beat per cycle, either as a critical-word-first
// WRAP burst covering the full line or as an INCR burst from the start beat
// to the end of the line. The next line is popped on the last-beat handshake
// so consecutive bursts flow without a bubble.
module cc_wrap_serializer #(
  parameter int DATA_W = 64,
  parameter int BEATS  = 8,
  localparam int OFS_W = $clog2(BEATS),
  localparam int ENT_W = 1 + OFS_W + DATA_W*BEATS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fifo_empty_i,
  input  logic [ENT_W-1:0]  fifo_rdata_i,
  output logic              fifo_rden_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              rlast_o,
  output logic              rvalid_o,
  input  logic              rready_i,
  output logic              busy_o
);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t                  state_reg, state_next;
  logic [DATA_W*BEATS-1:0] line_reg, line_next;
  logic                    mode_reg, mode_next;   // 0 = WRAP, 1 = INCR
  logic [OFS_W-1:0]        start_reg, start_next;
  logic [OFS_W-1:0]        cnt_reg, cnt_next;

  logic [DATA_W-1:0]       beat_arr [BEATS];
  logic [OFS_W-1:0]        last_cnt;
  logic [OFS_W-1:0]        beat_idx;
  logic                    send;
  logic                    is_last;
  logic                    fire;
  logic                    pop;

  // Split the held line into addressable beats.
  generate
    for (genvar gi = 0; gi < BEATS; gi++) begin : g_beat
      assign beat_arr[gi] = line_reg[gi*DATA_W +: DATA_W];
    end
  endgenerate

  assign send = (state_reg == SEND);

  // Final count value: BEATS-1 for WRAP; BEATS-1-S for INCR, which in
  // OFS_W-bit arithmetic is simply the bitwise inverse of S.
  assign last_cnt = mode_reg ? ~start_reg : {OFS_W{1'b1}};

  assign is_last  = send && (cnt_reg == last_cnt);
  assign fire     = send && rready_i;

  // Wrap arithmetic relies on natural OFS_W-bit overflow.
  assign beat_idx = start_reg + cnt_reg;

  // Pop when idle with data waiting, or on the last-beat handshake so the
  // next burst starts on the very next cycle. Reset blocks any pop.
  assign pop = !rst && !fifo_empty_i && (!send || (fire && is_last));

  // State register: async reset clears everything, so rdata_o reads 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      line_reg  <= '0;
      mode_reg  <= 1'b0;
      start_reg <= '0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      line_reg  <= line_next;
      mode_reg  <= mode_next;
      start_reg <= start_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Next-state and output decode: load on pop, advance on handshake.
  always_comb begin
    state_next  = state_reg;
    line_next   = line_reg;
    mode_next   = mode_reg;
    start_next  = start_reg;
    cnt_next    = cnt_reg;
    fifo_rden_o = 1'b0;
    rvalid_o    = send;
    rlast_o     = is_last;
    busy_o      = send;
    rdata_o     = beat_arr[beat_idx];

    if (pop) begin
      fifo_rden_o = 1'b1;
      line_next   = fifo_rdata_i[DATA_W*BEATS-1:0];
      mode_next   = fifo_rdata_i[ENT_W-1];
      start_next  = fifo_rdata_i[ENT_W-2 -: OFS_W];
      cnt_next    = '0;
      state_next  = SEND;
    end else if (fire) begin
      if (is_last) begin
        state_next = IDLE;
      end else begin
        cnt_next = cnt_reg + 1'b1;
      end
    end
  end

  // A pop must never be issued against an empty FIFO.
  assert property (@(posedge clk) disable iff (rst) !(fifo_rden_o && fifo_empty_i));

  // The last-beat flag only accompanies a valid beat.
  assert property (@(posedge clk) disable iff (rst) !(rlast_o && !rvalid_o));

endmodule

// File: tb/tb_cc_wrap_serializer.sv
// Scoreboard bench for cc_wrap_serializer: a default instance (64x8) and a
// 32x4 instance, each fed from a queue-modelled show-ahead FIFO. Expected
// beats are pushed when an entry is popped and compared as beats are
// accepted; valid/busy/pop timing is checked against the scoreboard state.
module tb_cc_wrap_serializer;

  localparam int DW_A = 64;
  localparam int BT_A = 8;
  localparam int OW_A = 3;
  localparam int EW_A = 1 + OW_A + DW_A*BT_A;
  localparam int DW_B = 32;
  localparam int BT_B = 4;
  localparam int OW_B = 2;
  localparam int EW_B = 1 + OW_B + DW_B*BT_B;

  typedef struct {
    logic [63:0] data;
    logic        last;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic            a_empty, a_rden, a_last, a_valid, a_ready, a_busy;
  logic [EW_A-1:0] a_rdata;
  logic [DW_A-1:0] a_data;
  logic            b_empty, b_rden, b_last, b_valid, b_ready, b_busy;
  logic [EW_B-1:0] b_rdata;
  logic [DW_B-1:0] b_data;

  logic [EW_A-1:0] a_fifo [$];
  logic [EW_B-1:0] b_fifo [$];
  beat_t           a_exp [$];
  beat_t           b_exp [$];

  int n_checks = 0;
  int n_fail   = 0;
  int rr_mode  = 0;
  int rr_idx   = 0;
  int rr_pat [4] = '{1, 0, 0, 1};

  cc_wrap_serializer #(.DATA_W(DW_A), .BEATS(BT_A)) u_dut_a (
    .clk          (clk),
    .rst          (rst),
    .fifo_empty_i (a_empty),
    .fifo_rdata_i (a_rdata),
    .fifo_rden_o  (a_rden),
    .rdata_o      (a_data),
    .rlast_o      (a_last),
    .rvalid_o     (a_valid),
    .rready_i     (a_ready),
    .busy_o       (a_busy)
  );

  cc_wrap_serializer #(.DATA_W(DW_B), .BEATS(BT_B)) u_dut_b (
    .clk          (clk),
    .rst          (rst),
    .fifo_empty_i (b_empty),
    .fifo_rdata_i (b_rdata),
    .fifo_rden_o  (b_rden),
    .rdata_o      (b_data),
    .rlast_o      (b_last),
    .rvalid_o     (b_valid),
    .rready_i     (b_ready),
    .busy_o       (b_busy)
  );

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [EW_A-1:0] mk_a(input bit mode, input int s, input int tag);
    logic [EW_A-1:0] e;
    e = '0;
    e[EW_A-1] = mode;
    e[EW_A-2 -: OW_A] = s[OW_A-1:0];
    for (int k = 0; k < BT_A; k++) e[k*DW_A +: DW_A] = {tag[31:0], k[31:0]};
    return e;
  endfunction

  function automatic logic [EW_B-1:0] mk_b(input bit mode, input int s, input int tag);
    logic [EW_B-1:0] e;
    e = '0;
    e[EW_B-1] = mode;
    e[EW_B-2 -: OW_B] = s[OW_B-1:0];
    for (int k = 0; k < BT_B; k++) e[k*DW_B +: DW_B] = {tag[15:0], k[15:0]};
    return e;
  endfunction

  // Expected beat sequence of an entry: S, S+1, ... modulo BEATS.
  function automatic void expand_a(input logic [EW_A-1:0] e);
    int s, len, idx;
    beat_t b;
    s   = int'(e[EW_A-2 -: OW_A]);
    len = e[EW_A-1] ? BT_A - s : BT_A;
    for (int c = 0; c < len; c++) begin
      idx    = (s + c) % BT_A;
      b.data = 64'(e[idx*DW_A +: DW_A]);
      b.last = (c == len - 1);
      a_exp.push_back(b);
    end
  endfunction

  function automatic void expand_b(input logic [EW_B-1:0] e);
    int s, len, idx;
    beat_t b;
    s   = int'(e[EW_B-2 -: OW_B]);
    len = e[EW_B-1] ? BT_B - s : BT_B;
    for (int c = 0; c < len; c++) begin
      idx    = (s + c) % BT_B;
      b.data = 64'(e[idx*DW_B +: DW_B]);
      b.last = (c == len - 1);
      b_exp.push_back(b);
    end
  endfunction

  task automatic check_a();
    logic  hs, exp_pop;
    beat_t e;
    hs      = a_valid && a_ready;
    exp_pop = !a_empty && (a_exp.size() == 0 || (a_exp.size() == 1 && hs));
    check_val("a_valid", 64'(a_valid), 64'(a_exp.size() != 0));
    check_val("a_busy", 64'(a_busy), 64'(a_exp.size() != 0));
    check_val("a_rden", 64'(a_rden), 64'(exp_pop));
    if (a_valid && a_exp.size() != 0) begin
      e = a_exp[0];
      check_val("a_data", 64'(a_data), e.data);
      check_val("a_last", 64'(a_last), 64'(e.last));
      if (hs) begin
        void'(a_exp.pop_front());
        $display("A beat data=%h last=%0d", a_data, a_last);
      end
    end else if (!a_valid) begin
      check_val("a_last_idle", 64'(a_last), 64'd0);
    end
    if (a_rden && !a_empty) expand_a(a_fifo.pop_front());
  endtask

  task automatic check_b();
    logic  hs, exp_pop;
    beat_t e;
    hs      = b_valid && b_ready;
    exp_pop = !b_empty && (b_exp.size() == 0 || (b_exp.size() == 1 && hs));
    check_val("b_valid", 64'(b_valid), 64'(b_exp.size() != 0));
    check_val("b_busy", 64'(b_busy), 64'(b_exp.size() != 0));
    check_val("b_rden", 64'(b_rden), 64'(exp_pop));
    if (b_valid && b_exp.size() != 0) begin
      e = b_exp[0];
      check_val("b_data", 64'(b_data), e.data);
      check_val("b_last", 64'(b_last), 64'(e.last));
      if (hs) begin
        void'(b_exp.pop_front());
        $display("B beat data=%h last=%0d", b_data, b_last);
      end
    end else if (!b_valid) begin
      check_val("b_last_idle", 64'(b_last), 64'd0);
    end
    if (b_rden && !b_empty) expand_b(b_fifo.pop_front());
  endtask

  // One clock cycle: drive inputs after the edge, check at the falling edge.
  task automatic step();
    logic rr;
    a_empty = (a_fifo.size() == 0);
    a_rdata = a_empty ? '0 : a_fifo[0];
    b_empty = (b_fifo.size() == 0);
    b_rdata = b_empty ? '0 : b_fifo[0];
    case (rr_mode)
      1:       rr = rr_pat[rr_idx % 4] != 0;
      2:       rr = $urandom_range(0, 1) != 0;
      default: rr = 1'b1;
    endcase
    rr_idx++;
    a_ready = rr;
    b_ready = rr;
    @(negedge clk);
    if (rst) begin
      check_val("rst_a_valid", 64'(a_valid), 64'd0);
      check_val("rst_a_last", 64'(a_last), 64'd0);
      check_val("rst_a_rden", 64'(a_rden), 64'd0);
      check_val("rst_a_busy", 64'(a_busy), 64'd0);
      check_val("rst_a_data", 64'(a_data), 64'd0);
      check_val("rst_b_valid", 64'(b_valid), 64'd0);
      check_val("rst_b_rden", 64'(b_rden), 64'd0);
      a_exp.delete();
      b_exp.delete();
    end else begin
      check_a();
      check_b();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int max_cyc);
    int n;
    n = 0;
    while ((a_fifo.size() != 0 || a_exp.size() != 0 ||
            b_fifo.size() != 0 || b_exp.size() != 0) && n < max_cyc) begin
      step();
      n++;
    end
    check_val("drain_done", 64'(n < max_cyc), 64'd1);
    a_fifo.delete();
    b_fifo.delete();
    a_exp.delete();
    b_exp.delete();
  endtask

  initial begin
    a_ready = 1'b1;
    b_ready = 1'b1;
    a_empty = 1'b1;
    b_empty = 1'b1;
    a_rdata = '0;
    b_rdata = '0;

    // Reset state, FIFO holding an entry: no pop may occur.
    a_fifo.push_back(mk_a(1'b0, 1, 99));
    repeat (3) step();
    a_fifo.delete();
    rst = 1'b0;
    repeat (2) step();

    // WRAP S=2, ready held high: 2..7,0,1 cycle-exact after the pop.
    a_fifo.push_back(mk_a(1'b0, 2, 1));
    drain(40);
    step();

    // INCR S=5: beats 5,6,7 then idle.
    a_fifo.push_back(mk_a(1'b1, 5, 2));
    drain(40);
    repeat (2) step();

    // Backpressure 1,0,0,1 during WRAP S=0.
    rr_mode = 1;
    rr_idx  = 0;
    a_fifo.push_back(mk_a(1'b0, 0, 3));
    drain(80);
    rr_mode = 0;
    step();

    // Back-to-back: WRAP S=7 then INCR S=6, ten beats without a gap.
    a_fifo.push_back(mk_a(1'b0, 7, 4));
    a_fifo.push_back(mk_a(1'b1, 6, 5));
    drain(40);
    step();

    // Narrow instance: WRAP S=3 gives 3,0,1,2.
    b_fifo.push_back(mk_b(1'b0, 3, 6));
    b_fifo.push_back(mk_b(1'b1, 2, 7));
    drain(40);
    step();

    // Reset after three beats of a burst; empty FIFO afterwards.
    a_fifo.push_back(mk_a(1'b0, 4, 8));
    step();
    repeat (3) step();
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    repeat (4) step();

    // Random modes, start beats and ready on both instances.
    rr_mode = 2;
    for (int i = 0; i < 12; i++) begin
      a_fifo.push_back(mk_a(bit'($urandom_range(0, 1)), int'($urandom_range(0, 7)), 100 + i));
      b_fifo.push_back(mk_b(bit'($urandom_range(0, 1)), int'($urandom_range(0, 3)), 200 + i));
    end
    drain(800);
    rr_mode = 0;
    repeat (2) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
